// File: rtl/cpu_control_pkg.sv
// cpu_control_pkg: shared constants and decode helpers for the CR16-style
// multicycle controller.
//   - FSM state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3)
//   - opcode / opext / condition-code constants
//   - PSR bit indices into psrOut {C,Z,F,L,N} = [4:0]
//   - ALUOp_* operation encodings consumed by reg_alu
//   - decode(): maps opcode + imm8 to an instruction class and ALU controls
package cpu_control_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    MEM    = 2'd3
  } state_e;

  // Primary opcodes [15:12]
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_MEMJ  = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  // ALU opext values; the immediate forms reuse them as opcodes
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_MOV = 4'b1101;
  localparam logic [3:0] EXT_LUI = 4'b1111;

  // Shift opext values
  localparam logic [3:0] EXT_LSH    = 4'b0100;
  localparam logic [3:0] EXT_LSHI_L = 4'b0000;
  localparam logic [3:0] EXT_LSHI_R = 4'b0001;
  localparam logic [3:0] EXT_ARSHI  = 4'b0010;

  // Memory / jump opext values
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_HI = 4'b0100;
  localparam logic [3:0] COND_LS = 4'b0101;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_LO = 4'b1010;
  localparam logic [3:0] COND_HS = 4'b1011;
  localparam logic [3:0] COND_LT = 4'b1100;
  localparam logic [3:0] COND_GE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;

  // PSR bit indices
  localparam int PSR_C = 4;
  localparam int PSR_Z = 3;
  localparam int PSR_F = 2;
  localparam int PSR_L = 1;
  localparam int PSR_N = 0;

  // ALU operation encodings
  localparam logic [4:0] ALUOp_ADD = 5'd0;
  localparam logic [4:0] ALUOp_SUB = 5'd1;
  localparam logic [4:0] ALUOp_CMP = 5'd2;
  localparam logic [4:0] ALUOp_AND = 5'd3;
  localparam logic [4:0] ALUOp_OR  = 5'd4;
  localparam logic [4:0] ALUOp_XOR = 5'd5;
  localparam logic [4:0] ALUOp_MOV = 5'd6;
  localparam logic [4:0] ALUOp_LUI = 5'd7;
  localparam logic [4:0] ALUOp_SLL = 5'd8;
  localparam logic [4:0] ALUOp_SRL = 5'd9;
  localparam logic [4:0] ALUOp_SRA = 5'd10;

  // Mux encodings
  localparam logic [1:0] WB_PC  = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b10;
  localparam logic [1:0] WB_MEM = 2'b11;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  typedef enum logic [2:0] {
    K_ILLEGAL = 3'd0,
    K_ALU     = 3'd1,
    K_BCOND   = 3'd2,
    K_JAL     = 3'd3,
    K_JCOND   = 3'd4,
    K_LOAD    = 3'd5,
    K_STOR    = 3'd6
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic [4:0] alu_op;
    logic       imm_sel;   // B operand from imm_in
    logic [7:0] imm;
    logic       rf_write;  // ALU result is written back
  } decode_t;

  // Basic ALU group shared by register (opext) and immediate (opcode) forms.
  // Returns {valid, alu_op}. LUI exists only as an immediate form.
  function automatic logic [5:0] basic_alu(input logic [3:0] code, input logic allow_lui);
    logic [5:0] r;
    r = {1'b1, ALUOp_ADD};
    case (code)
      EXT_ADD: r[4:0] = ALUOp_ADD;
      EXT_SUB: r[4:0] = ALUOp_SUB;
      EXT_CMP: r[4:0] = ALUOp_CMP;
      EXT_AND: r[4:0] = ALUOp_AND;
      EXT_OR:  r[4:0] = ALUOp_OR;
      EXT_XOR: r[4:0] = ALUOp_XOR;
      EXT_MOV: r[4:0] = ALUOp_MOV;
      EXT_LUI: begin
        r[4:0] = ALUOp_LUI;
        r[5]   = allow_lui;
      end
      default: r[5] = 1'b0;
    endcase
    return r;
  endfunction

  // opcode = IR[15:12], imm8 = IR[7:0] (opext is imm8[7:4]).
  function automatic decode_t decode(input logic [3:0] opcode, input logic [7:0] imm8);
    decode_t    d;
    logic [3:0] ext;
    logic [5:0] b;
    ext       = imm8[7:4];
    d.kind    = K_ILLEGAL;
    d.alu_op  = ALUOp_ADD;
    d.imm_sel = 1'b0;
    d.imm     = 8'h00;
    d.rf_write = 1'b0;
    case (opcode)
      OP_REG: begin
        b = basic_alu(ext, 1'b0);
        if (b[5]) begin
          d.kind   = K_ALU;
          d.alu_op = b[4:0];
        end
      end
      OP_SHIFT: begin
        case (ext)
          EXT_LSH: begin
            d.kind   = K_ALU;
            d.alu_op = ALUOp_SLL;
          end
          EXT_LSHI_L, EXT_LSHI_R, EXT_ARSHI: begin
            d.kind    = K_ALU;
            d.imm_sel = 1'b1;
            d.imm     = {4'b0000, imm8[3:0]};
            d.alu_op  = (ext == EXT_LSHI_L) ? ALUOp_SLL :
                        (ext == EXT_LSHI_R) ? ALUOp_SRL : ALUOp_SRA;
          end
          default: d.kind = K_ILLEGAL;
        endcase
      end
      OP_MEMJ: begin
        case (ext)
          EXT_LOAD:  d.kind = K_LOAD;
          EXT_STOR:  d.kind = K_STOR;
          EXT_JAL:   d.kind = K_JAL;
          EXT_JCOND: d.kind = K_JCOND;
          default:   d.kind = K_ILLEGAL;
        endcase
      end
      OP_BCOND: begin
        d.kind = K_BCOND;
        d.imm  = imm8;
      end
      default: begin
        b = basic_alu(opcode, 1'b1);
        if (b[5]) begin
          d.kind    = K_ALU;
          d.alu_op  = b[4:0];
          d.imm_sel = 1'b1;
          d.imm     = imm8;
        end
      end
    endcase
    d.rf_write = (d.kind == K_ALU) && (d.alu_op != ALUOp_CMP);
    return d;
  endfunction

endpackage

// File: rtl/cpu_control_if.sv
// cpu_control_if: control bundle between the instruction controller and the
// datapath (reg_alu, PC unit, memory port).
//   ctrl modport: inst, mem_rdy, psrOut in; every control strobe/select out.
//   dp   modport: the mirror view for the datapath side.
interface cpu_control_if;
  logic [15:0] inst;
  logic        mem_rdy;
  logic [4:0]  psrOut;
  logic        write;
  logic        IMM_MUX;
  logic [1:0]  WB_MUX;
  logic        COND_RSLT;
  logic [3:0]  rSrc;
  logic [3:0]  rDst;
  logic [4:0]  aluOp;
  logic [7:0]  imm_in;
  logic        psr_en;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        addr_sel;
  logic        mem_re;
  logic        mem_we;
  logic        illegal;

  modport ctrl (
    input  inst, mem_rdy, psrOut,
    output write, IMM_MUX, WB_MUX, COND_RSLT, rSrc, rDst, aluOp, imm_in,
           psr_en, pc_en, pc_sel, addr_sel, mem_re, mem_we, illegal
  );

  modport dp (
    output inst, mem_rdy, psrOut,
    input  write, IMM_MUX, WB_MUX, COND_RSLT, rSrc, rDst, aluOp, imm_in,
           psr_en, pc_en, pc_sel, addr_sel, mem_re, mem_we, illegal
  );
endinterface

// File: rtl/cpu_control_cond_eval.sv
// cond_eval: combinational branch/jump condition evaluator.
//   cond   in 4 : condition code (IR[11:8])
//   psr    in 5 : flags {C,Z,F,L,N} = [4:0]
//   result out 1: condition holds
module cond_eval
  import cpu_control_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] psr,
  output logic       result
);
  logic c, z, f, l, n;
  assign c = psr[PSR_C];
  assign z = psr[PSR_Z];
  assign f = psr[PSR_F];
  assign l = psr[PSR_L];
  assign n = psr[PSR_N];

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a
    // value on every path, otherwise synthesis infers a latch.
    result = 1'b0;
    case (cond)
      COND_EQ: result = z;
      COND_NE: result = !z;
      COND_CS: result = c;
      COND_CC: result = !c;
      COND_HI: result = l;
      COND_LS: result = !l;
      COND_GT: result = n;
      COND_LE: result = !n;
      COND_FS: result = f;
      COND_FC: result = !f;
      COND_LO: result = !l && !z;
      COND_HS: result = l || z;
      COND_LT: result = !n && !z;
      COND_GE: result = n || z;
      COND_UC: result = 1'b1;
      default: result = 1'b0;   // 1111: never
    endcase
  end
endmodule

// File: rtl/cpu_control.sv
// cpu_control: multicycle FETCH/DECODE/EXEC/MEM instruction controller.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : cpu_control_if.ctrl -- instruction/memory handshake and PSR
//              in, all reg_alu / PC / memory controls out.
// Outputs are purely combinational from state and IR; while rst is high they
// are held at their defaults so a reset mid-access drops the memory strobes
// immediately.
module cpu_control
  import cpu_control_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cpu_control_if.ctrl  bus
);
  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  decode_t     dec;
  logic        cond_true;

  logic       write, imm_mux, cond_rslt, psr_en, pc_en, addr_sel;
  logic       mem_re, mem_we, illegal;
  logic [1:0] wb_mux, pc_sel;
  logic [3:0] r_src, r_dst;
  logic [4:0] alu_op;
  logic [7:0] imm_in;

  assign dec = decode(ir_q[15:12], ir_q[7:0]);

  cond_eval u_cond_eval (
    .cond   (ir_q[11:8]),
    .psr    (bus.psrOut),
    .result (cond_true)
  );

  // NOTE: state flops use non-blocking '<=' so every flop samples pre-edge
  // values. IR is reset too: 0x0000 decodes as illegal, so nothing executes
  // from a stale register after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    write     = 1'b0;
    imm_mux   = 1'b0;
    wb_mux    = WB_ALU;
    cond_rslt = 1'b0;
    r_src     = 4'h0;
    r_dst     = 4'h0;
    alu_op    = 5'd0;
    imm_in    = 8'h00;
    psr_en    = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = PC_INC;
    addr_sel  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    illegal   = 1'b0;

    if (!rst) begin
      // Register indices and operand selects are stable from DECODE onward so
      // the register file read has settled before EXEC/MEM uses it.
      if (state_q != FETCH) begin
        r_src   = ir_q[3:0];
        r_dst   = ir_q[11:8];
        alu_op  = dec.alu_op;
        imm_mux = dec.imm_sel;
        imm_in  = dec.imm;
      end

      case (state_q)
        FETCH: begin
          mem_re = 1'b1;
          if (bus.mem_rdy) begin
            ir_d    = bus.inst;
            pc_en   = 1'b1;
            state_d = DECODE;
          end
        end

        DECODE: begin
          state_d = (dec.kind == K_LOAD || dec.kind == K_STOR) ? MEM : EXEC;
        end

        EXEC: begin
          state_d = FETCH;
          case (dec.kind)
            K_ALU: begin
              write  = dec.rf_write;
              psr_en = 1'b1;
            end
            K_BCOND: begin
              cond_rslt = cond_true;
              if (cond_true) begin
                pc_en  = 1'b1;
                pc_sel = PC_REL;
              end
            end
            K_JAL: begin
              // Link write and PC load share this edge; the PC unit samples
              // dSrc before the write lands, so Rdest==Rsrc is safe.
              write  = 1'b1;
              wb_mux = WB_PC;
              pc_en  = 1'b1;
              pc_sel = PC_REG;
            end
            K_JCOND: begin
              cond_rslt = cond_true;
              if (cond_true) begin
                pc_en  = 1'b1;
                pc_sel = PC_REG;
              end
            end
            default: illegal = 1'b1;
          endcase
        end

        MEM: begin
          addr_sel = 1'b1;
          mem_re   = (dec.kind == K_LOAD);
          mem_we   = (dec.kind == K_STOR);
          if (bus.mem_rdy) begin
            if (dec.kind == K_LOAD) begin
              write  = 1'b1;
              wb_mux = WB_MEM;
            end
            state_d = FETCH;
          end
        end

        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.write     = write;
  assign bus.IMM_MUX   = imm_mux;
  assign bus.WB_MUX    = wb_mux;
  assign bus.COND_RSLT = cond_rslt;
  assign bus.rSrc      = r_src;
  assign bus.rDst      = r_dst;
  assign bus.aluOp     = alu_op;
  assign bus.imm_in    = imm_in;
  assign bus.psr_en    = psr_en;
  assign bus.pc_en     = pc_en;
  assign bus.pc_sel    = pc_sel;
  assign bus.addr_sel  = addr_sel;
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.illegal   = illegal;

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control. Outputs are sampled 1 time unit after the
// rising edge; inputs change at the same points.
module tb_cpu_control;
  import cpu_control_pkg::*;

  logic clk = 1'b0;
  logic rst;

  cpu_control_if bus ();

  cpu_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called while in FETCH: present an instruction with mem_rdy high and
  // advance to the EXEC (or MEM) cycle.
  task automatic issue(input logic [15:0] i);
    bus.inst    = i;
    bus.mem_rdy = 1'b1;
    next_cycle();   // DECODE
    next_cycle();   // EXEC / MEM
  endtask

  initial begin
    rst         = 1'b1;
    bus.inst    = 16'h0000;
    bus.mem_rdy = 1'b0;
    bus.psrOut  = 5'b00000;

    // Reset: all outputs at defaults
    #12;
    check("rst_mem_re", bus.mem_re, 0);
    check("rst_wb_mux", bus.WB_MUX, WB_ALU);
    check("rst_pc_en",  bus.pc_en,  0);
    check("rst_write",  bus.write,  0);

    // ADDI r1,10
    @(negedge clk);
    rst         = 1'b0;
    bus.inst    = 16'h510A;
    bus.mem_rdy = 1'b1;
    #1;
    check("addi_c1_mem_re",   bus.mem_re,   1);
    check("addi_c1_pc_en",    bus.pc_en,    1);
    check("addi_c1_pc_sel",   bus.pc_sel,   PC_INC);
    check("addi_c1_addr_sel", bus.addr_sel, 0);
    next_cycle();
    check("addi_c2_write",  bus.write,  0);
    check("addi_c2_pc_en",  bus.pc_en,  0);
    check("addi_c2_mem_re", bus.mem_re, 0);
    check("addi_c2_rdst",   bus.rDst,   1);
    next_cycle();
    check("addi_c3_write",   bus.write,   1);
    check("addi_c3_imm_mux", bus.IMM_MUX, 1);
    check("addi_c3_rdst",    bus.rDst,    1);
    check("addi_c3_imm_in",  bus.imm_in,  8'h0A);
    check("addi_c3_aluop",   bus.aluOp,   ALUOp_ADD);
    check("addi_c3_psr_en",  bus.psr_en,  1);
    check("addi_c3_wb_mux",  bus.WB_MUX,  WB_ALU);
    next_cycle();

    // CMP r1,r3
    issue(16'h01B3);
    check("cmp_write",   bus.write,   0);
    check("cmp_psr_en",  bus.psr_en,  1);
    check("cmp_rsrc",    bus.rSrc,    3);
    check("cmp_rdst",    bus.rDst,    1);
    check("cmp_imm_mux", bus.IMM_MUX, 0);
    check("cmp_aluop",   bus.aluOp,   ALUOp_CMP);
    next_cycle();

    // BEQ +4 taken (Z=1)
    bus.psrOut = 5'b01000;
    issue(16'hC004);
    check("beq_t_cond",   bus.COND_RSLT, 1);
    check("beq_t_pc_en",  bus.pc_en,     1);
    check("beq_t_pc_sel", bus.pc_sel,    PC_REL);
    check("beq_t_imm_in", bus.imm_in,    8'h04);
    check("beq_t_write",  bus.write,     0);
    next_cycle();

    // BEQ +4 not taken
    bus.psrOut = 5'b00000;
    issue(16'hC004);
    check("beq_n_cond",  bus.COND_RSLT, 0);
    check("beq_n_pc_en", bus.pc_en,     0);
    next_cycle();

    // LSHI right r0,5
    issue(16'h8015);
    check("lshr_aluop",   bus.aluOp,   ALUOp_SRL);
    check("lshr_imm_in",  bus.imm_in,  8'h05);
    check("lshr_imm_mux", bus.IMM_MUX, 1);
    check("lshr_write",   bus.write,   1);
    next_cycle();

    // Jcond NE r6 with Z=1: not taken
    bus.psrOut = 5'b01000;
    issue(16'h41C6);
    check("jne_cond",  bus.COND_RSLT, 0);
    check("jne_pc_en", bus.pc_en,     0);
    next_cycle();

    // Jcond UC r6: taken through dSrc
    issue(16'h4EC6);
    check("juc_cond",   bus.COND_RSLT, 1);
    check("juc_pc_en",  bus.pc_en,     1);
    check("juc_pc_sel", bus.pc_sel,    PC_REG);
    next_cycle();

    // LOAD r3,r2 with 3 stall cycles in MEM
    bus.inst    = 16'h4302;
    bus.mem_rdy = 1'b1;
    next_cycle();   // DECODE
    check("ld_dec_rsrc", bus.rSrc, 2);
    check("ld_dec_rdst", bus.rDst, 3);
    bus.mem_rdy = 1'b0;
    next_cycle();   // MEM
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ld_stall%0d_mem_re", k),   bus.mem_re,   1);
      check($sformatf("ld_stall%0d_addr_sel", k), bus.addr_sel, 1);
      check($sformatf("ld_stall%0d_write", k),    bus.write,    0);
      check($sformatf("ld_stall%0d_wb_mux", k),   bus.WB_MUX,   WB_ALU);
      next_cycle();
    end
    bus.mem_rdy = 1'b1;
    #1;
    check("ld_rdy_mem_re",   bus.mem_re,   1);
    check("ld_rdy_addr_sel", bus.addr_sel, 1);
    check("ld_rdy_write",    bus.write,    1);
    check("ld_rdy_wb_mux",   bus.WB_MUX,   WB_MEM);
    next_cycle();   // FETCH
    check("ld_after_addr_sel", bus.addr_sel, 0);
    check("ld_after_write",    bus.write,    0);

    // FETCH stall: no PC load until mem_rdy
    bus.mem_rdy = 1'b0;
    #1;
    check("fstall_pc_en",  bus.pc_en,  0);
    check("fstall_mem_re", bus.mem_re, 1);
    next_cycle();
    check("fstall2_mem_re", bus.mem_re, 1);
    check("fstall2_pc_en",  bus.pc_en,  0);

    // STOR r1,r2, reset asserted mid-MEM
    bus.inst    = 16'h4142;
    bus.mem_rdy = 1'b1;
    next_cycle();   // DECODE
    bus.mem_rdy = 1'b0;
    next_cycle();   // MEM
    check("st_mem_we",   bus.mem_we,   1);
    check("st_mem_re",   bus.mem_re,   0);
    check("st_addr_sel", bus.addr_sel, 1);
    check("st_rdst",     bus.rDst,     1);
    check("st_rsrc",     bus.rSrc,     2);
    #2;
    rst = 1'b1;
    #1;
    check("st_rst_mem_we",   bus.mem_we,   0);
    check("st_rst_mem_re",   bus.mem_re,   0);
    check("st_rst_addr_sel", bus.addr_sel, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("st_rel_mem_re", bus.mem_re, 1);
    check("st_rel_pc_en",  bus.pc_en,  0);

    // JAL r5,r6 fetched right after release
    bus.inst    = 16'h4586;
    bus.mem_rdy = 1'b1;
    #1;
    check("jal_fetch_pc_en", bus.pc_en, 1);
    next_cycle();   // DECODE
    next_cycle();   // EXEC
    check("jal_write",  bus.write,  1);
    check("jal_wb_mux", bus.WB_MUX, WB_PC);
    check("jal_rdst",   bus.rDst,   5);
    check("jal_rsrc",   bus.rSrc,   6);
    check("jal_pc_sel", bus.pc_sel, PC_REG);
    check("jal_pc_en",  bus.pc_en,  1);
    next_cycle();

    // Illegal opcode 0x7xxx: one-cycle pulse, no writes
    issue(16'h7123);
    check("ill_pulse",  bus.illegal, 1);
    check("ill_write",  bus.write,   0);
    check("ill_psr_en", bus.psr_en,  0);
    check("ill_pc_en",  bus.pc_en,   0);
    next_cycle();
    check("ill_after", bus.illegal, 0);
    check("ill_after_write", bus.write, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
